// File: rtl/sd_tx_nibble_fifo_pkg.sv
// Shared constants and helpers for the SD transmit nibble FIFO.
// Defaults mirror FIFO_TX_MEM_DEPTH / FIFO_TX_MEM_ADR_SIZE / SD_NIBBLE_W of the controller defines.
package sd_tx_nibble_fifo_pkg;

    localparam int unsigned FIFO_TX_MEM_DEPTH    = 8;
    localparam int unsigned FIFO_TX_MEM_ADR_SIZE = 4;
    localparam int unsigned SD_NIBBLE_W          = 4;

    typedef logic [2:0] nib_idx_t;

    localparam nib_idx_t NIB_LAST = 3'd7;

    // Nibble idx of a word, MSB first: idx0 = w[31:28] ... idx7 = w[3:0].
    function automatic logic [SD_NIBBLE_W-1:0] word_nibble(input logic [31:0] w,
                                                           input nib_idx_t    idx);
        logic [31:0] shifted;
        shifted = w << {idx, 2'b00};
        return shifted[31:28];
    endfunction

endpackage

// File: rtl/sd_fifo_ptr.sv
// Binary FIFO pointer with increment enable, synchronous clear (priority) and async reset.
module sd_fifo_ptr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sd_tx_nibble_fifo.sv
// SD transmit buffer: 32-bit words in, one 4-bit nibble out per accepted rd (MSB nibble first).
// Optional sticky underrun flag enabled by defining SD_TX_FIFO_UNDERRUN_EN.
module sd_tx_nibble_fifo
    import sd_tx_nibble_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_TX_MEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [31:0]              d,
    input  logic                     wr,
    input  logic                     rd,
    output logic [SD_NIBBLE_W-1:0]   q,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun
);

    localparam int unsigned ADR_W = $clog2(DEPTH) + 1;

    logic [ADR_W-1:0] wptr;
    logic [ADR_W-1:0] rptr;
    logic [31:0]      ram_q [DEPTH];
    nib_idx_t         nib_idx_q;
    nib_idx_t         nib_idx_d;
    logic             wr_ok;
    logic             rd_ok;
    logic             pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADR_W-2:0] == rptr[ADR_W-2:0]) && (wptr[ADR_W-1] != rptr[ADR_W-1]);
    assign level = wptr - rptr;

    // full/empty are pre-edge values, so a pop and a write to a full FIFO never pair up
    assign wr_ok = wr & ~full  & ~flush;
    assign rd_ok = rd & ~empty & ~flush;
    assign pop   = rd_ok & (nib_idx_q == NIB_LAST);

    sd_fifo_ptr #(.W(ADR_W)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (wr_ok),
        .ptr_o (wptr)
    );

    sd_fifo_ptr #(.W(ADR_W)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rptr)
    );

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ram_q[wptr[ADR_W-2:0]] <= d;
        end
    end

    always_comb begin
        nib_idx_d = nib_idx_q;
        if (flush) begin
            nib_idx_d = '0;
        end else if (rd_ok) begin
            nib_idx_d = nib_idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_idx_q <= '0;
        end else begin
            nib_idx_q <= nib_idx_d;
        end
    end

    assign q = word_nibble(ram_q[rptr[ADR_W-2:0]], nib_idx_q);

`ifdef SD_TX_FIFO_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 1'b0;
        end else if (flush) begin
            underrun_q <= 1'b0;
        end else if (rd & empty) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_sd_tx_nibble_fifo.sv
// Scoreboard bench for sd_tx_nibble_fifo: expected nibble stream kept as a queue of nibbles.
module tb_sd_tx_nibble_fifo;
    import sd_tx_nibble_fifo_pkg::*;

    localparam int DEPTH = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr    = 1'b0;
    logic        rd    = 1'b0;
    logic [31:0] d     = '0;
    logic [3:0]  q;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        underrun;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_nib[$];
    bit         exp_und = 1'b0;

    sd_tx_nibble_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .d        (d),
        .wr       (wr),
        .rd       (rd),
        .q        (q),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Whole words held: a partially read word still counts.
    function automatic int words();
        return (exp_nib.size() + 7) / 8;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: checks status every cycle and consumes one expected nibble per effective rd.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("empty", int'(empty), int'(words() == 0));
            chk("full", int'(full), int'(words() == DEPTH));
            chk("level", int'(level), words());
            chk("underrun", int'(underrun), int'(exp_und));
            if (flush) begin
                exp_nib.delete();
                exp_und = 1'b0;
            end else if (rd) begin
                if (exp_nib.size() > 0) begin
                    chk("q", int'(q), int'(exp_nib.pop_front()));
                end else begin
`ifdef SD_TX_FIFO_UNDERRUN_EN
                    exp_und = 1'b1;
`endif
                end
            end
        end
    end

    // One clock of stimulus; an accepted word enters the scoreboard once its edge has passed.
    task automatic step(input bit w, input logic [31:0] dat, input bit r, input bit f = 1'b0);
        bit acc;
        acc   = w && !f && (words() < DEPTH);
        wr    = w;
        d     = dat;
        rd    = r;
        flush = f;
        @(posedge clk);
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                exp_nib.push_back(dat[31 - 4*i -: 4]);
            end
        end
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word, MSB nibble first.
        step(1'b1, 32'h1234_5678, 1'b0);
        repeat (8) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Fill to full; extra write is dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        repeat (64) step(1'b0, '0, 1'b1);

        // Full, last nibble popped together with a write: write rejected.
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0);
        repeat (7) step(1'b0, '0, 1'b1);
        step(1'b1, 32'hCAFE_F00D, 1'b1);
        step(1'b0, '0, 1'b0);
        repeat (56) step(1'b0, '0, 1'b1);

        // Three laps to exercise pointer wrap.
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 0; i < DEPTH; i++)
                step(1'b1, 32'h0123_4567 + 32'(lap*DEPTH + i) * 32'h1111_1111, 1'b0);
            repeat (64) step(1'b0, '0, 1'b1);
        end

        // Read while empty, then flush; FIFO still works afterwards.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b1, 32'h9876_5432, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);

        // Asynchronous reset mid-word (idx 3, two words held).
        step(1'b1, 32'hFEDC_BA98, 1'b0);
        step(1'b1, 32'h1357_9BDF, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1);
        wr = 1'b0;
        rd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_full", int'(full), 0);
        chk("async_rst_underrun", int'(underrun), 0);
        exp_nib.delete();
        exp_und = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 32'hA5C3_0F96, 1'b0);
        repeat (8) step(1'b0, '0, 1'b1);

        // Random traffic with occasional flush.
        for (int n = 0; n < 800; n++) begin
            step(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 59) == 0));
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
